clint_timer: RTL
================

Name: clint_timer

Overview:
- Machine timer and software-interrupt source; sits directly upstream of the CLIC.
- Keeps a free-running 64-bit mtime, a 64-bit mtimecmp and a per-hart msip bit.
- Drives the CLIC `timer_interrupt` and `ip_interrupt` inputs.
- Uses the same split addr/data IO-switch bus as the other IO slaves.

Parameters:
- RV, 64, bus data width (64 or 32).
- PRESCALE, 1, clk cycles per mtime increment (1..65535); 1 means increment every cycle.
- PRESCALE_BITS, 16, width of the prescale counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- addr_req  in  1  bus address phase request
- addr_ack  out  1  address accepted, same cycle
- sel_m  in  1  machine-mode select
- sel_s  in  1  supervisor-mode select
- sel_u  in  1  user-mode select
- addr  in  16  byte address
- read  in  1  1=read, 0=write
- mask  in  8  byte-lane write enables (RV=32 uses mask[3:0])
- wdata  in  RV  write data
- data_req  out  1  read data valid
- data_ack  in  1  read data consumed
- rdata  out  RV  read data
- tick_en  in  1  global mtime count enable (debug halt drives it to 0)
- timer_interrupt  out  1  registered (mtime >= mtimecmp)
- ip_interrupt  out  1  msip bit
- mtime  out  64  current time, for the time/timeh CSR shadow

Behaviour:
- addr_ack = addr_req & (sel_m|sel_s|sel_u), combinational; no wait states.
- Register map, addr[15:12]==4'b0000:
  - 0x000: msip, bit0, rest reads 0
  - 0x008: mtimecmp
  - 0x010: mtime
  - RV=32: 0x008/0x00C are mtimecmp lo/hi; 0x010/0x014 are mtime lo/hi.
  - Other offsets read 0; writes to them are ignored.
- Writes:
  - Accepted only when addr_req & sel_m & !read.
  - Each byte lane is written where its mask bit is 1.
  - sel_s/sel_u writes are acked and dropped.
- Reads:
  - Any selected read captures rdata on the clock edge after addr_req.
  - data_req rises that same edge and stays high until the cycle after data_ack.
  - reset or data_ack clears data_req; a new read in the same cycle as data_ack re-sets it (set wins).
  - rdata holds its value until the next read.
- Prescaler:
  - Counter runs 0..PRESCALE-1 while tick_en=1; tick pulses on wrap.
  - Counter freezes while tick_en=0.
  - PRESCALE=1 means tick = tick_en.
- mtime:
  - Increments by 1 on tick, wrapping 2^64-1 -> 0 with no flag.
  - A bus write to any mtime byte in the same cycle as a tick takes priority: written lanes take wdata, unwritten lanes keep the old value, no increment that cycle.
  - Any mtime write also clears the prescale counter.
- timer_interrupt:
  - Registered each cycle as (mtime >= mtimecmp), unsigned 64-bit compare of current register values.
  - Observed 1 cycle after mtime/mtimecmp change.
  - Level only; cleared solely by raising mtimecmp or lowering mtime.
- ip_interrupt = msip register, direct.
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - timer_interrupt=0, data_req=0, rdata=0, prescale counter=0.
- Reset asserted mid-read: data_req drops immediately; the pending read is lost.
- RV=32 two-write update of mtimecmp can transiently assert timer_interrupt; software writes hi=all-ones first. No hardware interlock.

Decomposition:
- Shared package (`clint_pkg`):
  - Address offsets: CLINT_MSIP=16'h0000, CLINT_MTIMECMP=16'h0008, CLINT_MTIME=16'h0010.
  - MTIMECMP_RESET constant.
  - Byte-lane merge function (old, new, mask).
- One sub-module, clint_prescale: counter, tick output, clear input, enable input.

Test Plan:
- Reset, then read 0x008 with sel_m → data_req one cycle after addr_req; rdata=64'hFFFF_FFFF_FFFF_FFFF; timer_interrupt=0; ip_interrupt=0.
- Write mtimecmp=10, PRESCALE=1, tick_en=1 → timer_interrupt rises on the cycle after mtime reaches 10; write mtimecmp=100 → falls 1 cycle later.
- Write msip=1 with sel_s → acked, ip_interrupt stays 0; same write with sel_m → ip_interrupt=1 the next cycle; write 0 → 0.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE with mask=8'hFF → after 2 ticks mtime=0 (wrap); write lanes mask=8'h0F with wdata=0x12345678 while ticking → upper word unchanged, lower=0x12345678, no increment that cycle.
- PRESCALE=4, tick_en toggled low for 3 cycles → mtime advances 1 per 4 enabled cycles; counter frozen while disabled.
- Read with data_ack held low 5 cycles → data_req stays 1 and rdata stable; back-to-back read issued with data_ack → data_req stays 1 with new rdata; reset mid-hold → data_req=0 asynchronously.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer block: register offsets, reset values
// and the byte-lane write merge used by every writable register.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP = 16'h0008;
    localparam logic [15:0] CLINT_MTIME    = 16'h0010;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } clint_reg_e;

    function automatic logic [63:0] lane_merge(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  lane_mask
    );
        logic [63:0] merged;
        merged = old_val;
        for (int unsigned i = 0; i < 8; i++) begin
            if (lane_mask[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_prescale.sv
// mtime prescaler: counts enabled cycles 0..PRESCALE-1 and pulses tick on wrap.
module clint_prescale #(
    parameter int PRESCALE      = 1,
    parameter int PRESCALE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam logic [PRESCALE_BITS-1:0] LAST = PRESCALE_BITS'(PRESCALE - 1);

    logic [PRESCALE_BITS-1:0] count;

    // With PRESCALE=1 the count is pinned at 0, so tick follows en directly.
    assign tick = en & (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + PRESCALE_BITS'(1);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Machine timer / software interrupt source on the split addr/data IO bus.
// Holds mtime, mtimecmp and msip; feeds the CLIC timer and IP interrupts.
module clint_timer
    import clint_pkg::*;
#(
    parameter int RV            = 64,
    parameter int PRESCALE      = 1,
    parameter int PRESCALE_BITS = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          addr_req,
    output logic          addr_ack,
    input  logic          sel_m,
    input  logic          sel_s,
    input  logic          sel_u,
    input  logic [15:0]   addr,
    input  logic          read,
    input  logic [7:0]    mask,
    input  logic [RV-1:0] wdata,
    output logic          data_req,
    input  logic          data_ack,
    output logic [RV-1:0] rdata,
    input  logic          tick_en,
    output logic          timer_interrupt,
    output logic          ip_interrupt,
    output logic [63:0]   mtime
);

    logic          any_sel;
    logic          wr_en;
    logic          rd_en;
    logic          mtime_wr;
    logic          tick;
    logic          msip;
    logic [63:0]   mtimecmp;
    logic [63:0]   wd64;
    logic [7:0]    m64;
    logic [63:0]   reg_val;
    logic [RV-1:0] rd_val;
    logic [15:0]   base;
    clint_reg_e    reg_sel;
    logic          unused_lsbs;

    assign any_sel  = sel_m | sel_s | sel_u;
    assign addr_ack = addr_req & any_sel;
    assign wr_en    = addr_req & sel_m & ~read;
    assign rd_en    = addr_req & any_sel & read;
    assign base     = {addr[15:3], 3'b000};

    always_comb begin
        reg_sel = REG_NONE;
        case (base)
            CLINT_MSIP:     reg_sel = REG_MSIP;
            CLINT_MTIMECMP: reg_sel = REG_MTIMECMP;
            CLINT_MTIME:    reg_sel = REG_MTIME;
            default:        reg_sel = REG_NONE;
        endcase
    end

    always_comb begin
        reg_val = '0;
        case (reg_sel)
            REG_MSIP:     reg_val = {63'd0, msip};
            REG_MTIMECMP: reg_val = mtimecmp;
            REG_MTIME:    reg_val = mtime;
            default:      reg_val = '0;
        endcase
    end

    // Narrow buses map each 32-bit access onto the matching half of the 64-bit lanes.
    if (RV == 64) begin : g_rv64
        assign wd64   = wdata;
        assign m64    = mask;
        assign rd_val = reg_val;
    end else begin : g_rv32
        assign wd64   = {wdata, wdata};
        assign m64    = addr[2] ? {mask[3:0], 4'h0} : {4'h0, mask[3:0]};
        assign rd_val = addr[2] ? reg_val[63:32] : reg_val[31:0];
    end

    assign unused_lsbs = ^{addr[2:0], mask[7:4]};

    assign mtime_wr     = wr_en & (reg_sel == REG_MTIME) & (|m64);
    assign ip_interrupt = msip;

    clint_prescale #(
        .PRESCALE      (PRESCALE),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clear (mtime_wr),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msip            <= 1'b0;
            mtimecmp        <= MTIMECMP_RESET;
            mtime           <= '0;
            timer_interrupt <= 1'b0;
            data_req        <= 1'b0;
            rdata           <= '0;
        end else begin
            if (wr_en && reg_sel == REG_MSIP && m64[0]) msip <= wd64[0];
            if (wr_en && reg_sel == REG_MTIMECMP) mtimecmp <= lane_merge(mtimecmp, wd64, m64);

            if (mtime_wr) begin
                mtime <= lane_merge(mtime, wd64, m64);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            timer_interrupt <= (mtime >= mtimecmp);

            if (rd_en) begin
                rdata    <= rd_val;
                data_req <= 1'b1;
            end else if (data_ack) begin
                data_req <= 1'b0;
            end
        end
    end

endmodule
